fadd_sched: RTL and testbench
=============================

FADD_SCHED -- requirements
Module: fadd_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of per-requester issue counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_valid_0 / req_valid_1  input  1  requester 0/1 has an operation pending.
REQ-005 SHALL have ports req_ready_0 / req_ready_1  output  1  operation accepted this cycle.
REQ-006 SHALL have ports req_x1_0, req_x2_0, req_x1_1, req_x2_1  input  32  IEEE single operands per requester.
REQ-007 SHALL have ports req_op_0 / req_op_1  input  1  0 = add, 1 = subtract (x1 - x2).
REQ-008 SHALL have ports fadd_x1 / fadd_x2  output  32  registered operands driving the shared 2-stage adder.
REQ-009 SHALL have port fadd_y  input  32  adder result, valid 2 cycles after operands are presented.
REQ-010 SHALL have ports resp_valid_0 / resp_valid_1  output  1  result for requester 0/1 on resp_y this cycle.
REQ-011 SHALL have port resp_y  output  32  result, equal to fadd_y.
REQ-012 SHALL have ports issue_cnt_0 / issue_cnt_1  output  CNT_W  operations accepted per requester.
REQ-013 SHALL have port idle  output  1  no handshake this cycle and no operation in flight.

Function
REQ-014 SHALL raise req_ready_i combinationally only for the granted requester; at most one ready high per cycle.
REQ-015 SHALL grant the sole valid requester; if both are valid, SHALL grant the requester not granted at the most recent handshake (round-robin).
REQ-016 SHALL update the last-granted pointer only on a handshake (valid and ready both high).
REQ-017 On a handshake SHALL register fadd_x1 = req_x1, and fadd_x2 = req_x2 with bit 31 inverted when op = 1, else unmodified.
REQ-018 SHALL hold fadd_x1/fadd_x2 unchanged in cycles without a handshake.
REQ-019 SHALL carry a valid bit and a 1-bit requester tag through a 3-deep shift register advancing every cycle.
REQ-020 For a handshake in cycle H, SHALL assert the tagged resp_valid for exactly one cycle, in cycle H+3, with resp_y = fadd_y.
REQ-021 SHALL sustain one handshake per cycle; back-to-back issues produce back-to-back responses in issue order.
REQ-022 SHALL never assert resp_valid_0 and resp_valid_1 in the same cycle.
REQ-023 SHALL increment issue_cnt_i by 1 per handshake of requester i, wrapping from 2^CNT_W-1 to 0.
REQ-024 SHALL drive idle = 1 iff no handshake this cycle and all three pipeline valid bits are 0.
REQ-025 Responses are not back-pressured; requesters SHALL accept resp_valid unconditionally.

Reset
REQ-026 While rst_n = 0 SHALL force: req_ready_* = 0, resp_valid_* = 0, fadd_x1 = fadd_x2 = 0, issue_cnt_* = 0, pipeline valid bits = 0, pointer such that requester 0 wins the first contention; idle = 1.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operations; no resp_valid for them after rst_n rises.
REQ-028 First handshake SHALL be possible in the first cycle with rst_n = 1.

Configuration
REQ-029 With macro FADD_SCHED_SUB_EN defined, req_op_* SHALL select add/subtract per REQ-017.
REQ-030 Without FADD_SCHED_SUB_EN, req_op_* SHALL be ignored and fadd_x2 = req_x2 unmodified on every handshake.

Verification
REQ-031 Requester 0 only, x1 = 0x3F800000, x2 = 0x40000000, op = 0 in cycle H -> resp_valid_0 = 1, resp_y = 0x40400000 in H+3 only.
REQ-032 Both valid continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; responses alternate 0,1,... starting 3 cycles later; issue_cnt_0 = issue_cnt_1 = 3.
REQ-033 With FADD_SCHED_SUB_EN: x1 = 0x40400000, x2 = 0x3F800000, op = 1 -> resp_y = 0x40000000; without macro, same stimulus -> 0x40800000.
REQ-034 Issue in cycle H, rst_n pulsed low in H+1 -> no resp_valid in H+3; issue_cnt_0 = 0; idle = 1 after reset.
REQ-035 issue_cnt_1 preloaded to 0xFFFF by 65535 handshakes (CNT_W = 16), one more handshake -> issue_cnt_1 = 0x0000.
REQ-036 Single issue then no traffic -> idle = 0 in cycles H..H+3, idle = 1 from H+4.

Source files
------------

// File: rtl/fadd_sched_if.sv
// Bundle of requester, adder and response signals for fadd_sched.
// slave is the scheduler's view; master is the surrounding system's view.
interface fadd_sched_if #(
  parameter int CNT_W = 16
);
  logic             req_valid_0;
  logic             req_valid_1;
  logic             req_ready_0;
  logic             req_ready_1;
  logic [31:0]      req_x1_0;
  logic [31:0]      req_x2_0;
  logic [31:0]      req_x1_1;
  logic [31:0]      req_x2_1;
  logic             req_op_0;
  logic             req_op_1;
  logic [31:0]      fadd_x1;
  logic [31:0]      fadd_x2;
  logic [31:0]      fadd_y;
  logic             resp_valid_0;
  logic             resp_valid_1;
  logic [31:0]      resp_y;
  logic [CNT_W-1:0] issue_cnt_0;
  logic [CNT_W-1:0] issue_cnt_1;
  logic             idle;

  modport slave (
    input  req_valid_0, req_valid_1, req_x1_0, req_x2_0, req_x1_1, req_x2_1,
           req_op_0, req_op_1, fadd_y,
    output req_ready_0, req_ready_1, fadd_x1, fadd_x2, resp_valid_0,
           resp_valid_1, resp_y, issue_cnt_0, issue_cnt_1, idle
  );

  modport master (
    output req_valid_0, req_valid_1, req_x1_0, req_x2_0, req_x1_1, req_x2_1,
           req_op_0, req_op_1, fadd_y,
    input  req_ready_0, req_ready_1, fadd_x1, fadd_x2, resp_valid_0,
           resp_valid_1, resp_y, issue_cnt_0, issue_cnt_1, idle
  );
endinterface

// File: rtl/fadd_sched.sv
// Round-robin scheduler sharing one 2-stage FP adder between two requesters.
// Define FADD_SCHED_SUB_EN to let req_op_* select subtract (x1 - x2).
module fadd_sched #(
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  fadd_sched_if.slave bus
);

  logic             grant_s;
  logic             ready_0_s;
  logic             ready_1_s;
  logic             hs_s;
  logic [31:0]      x1_s;
  logic [31:0]      x2_s;
  logic             op_s;
  logic [31:0]      x2_cond_s;
  logic             last_r;
  logic [31:0]      fadd_x1_r;
  logic [31:0]      fadd_x2_r;
  logic [2:0]       pv_r;
  logic [2:0]       ptag_r;
  logic [CNT_W-1:0] cnt_0_r;
  logic [CNT_W-1:0] cnt_1_r;

  // Subtraction is addition with the second operand's sign flipped.
  function automatic logic [31:0] negate_if(input logic [31:0] x, input logic neg);
    return {x[31] ^ neg, x[30:0]};
  endfunction

  // Grant: sole valid requester wins; on contention the one not granted last time.
  always_comb begin
    grant_s = 1'b0;
    if (bus.req_valid_0 && bus.req_valid_1) begin
      grant_s = ~last_r;
    end else if (bus.req_valid_1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign ready_0_s = rst_n & bus.req_valid_0 & ~grant_s;
  assign ready_1_s = rst_n & bus.req_valid_1 & grant_s;
  assign hs_s      = ready_0_s | ready_1_s;

  // Operand select for the granted requester.
  always_comb begin
    x1_s = bus.req_x1_0;
    x2_s = bus.req_x2_0;
    op_s = bus.req_op_0;
    if (grant_s) begin
      x1_s = bus.req_x1_1;
      x2_s = bus.req_x2_1;
      op_s = bus.req_op_1;
    end else begin
      x1_s = bus.req_x1_0;
      x2_s = bus.req_x2_0;
      op_s = bus.req_op_0;
    end
  end

`ifdef FADD_SCHED_SUB_EN
  assign x2_cond_s = negate_if(x2_s, op_s);
`else
  assign x2_cond_s = negate_if(x2_s, 1'b0);
  logic unused_op_s;
  assign unused_op_s = op_s;
`endif

  // Adder operand registers and round-robin pointer, updated only on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fadd_x1_r <= 32'h0000_0000;
      fadd_x2_r <= 32'h0000_0000;
      last_r    <= 1'b1;
    end else if (hs_s) begin
      fadd_x1_r <= x1_s;
      fadd_x2_r <= x2_cond_s;
      last_r    <= grant_s;
    end
  end

  // Valid/tag shift register matching operand register plus adder latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_r   <= 3'b000;
      ptag_r <= 3'b000;
    end else begin
      pv_r   <= {pv_r[1:0], hs_s};
      ptag_r <= {ptag_r[1:0], grant_s};
    end
  end

  // Per-requester issue counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_0_r <= {CNT_W{1'b0}};
      cnt_1_r <= {CNT_W{1'b0}};
    end else begin
      if (ready_0_s) begin
        cnt_0_r <= cnt_0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (ready_1_s) begin
        cnt_1_r <= cnt_1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.req_ready_0  = ready_0_s;
  assign bus.req_ready_1  = ready_1_s;
  assign bus.fadd_x1      = fadd_x1_r;
  assign bus.fadd_x2      = fadd_x2_r;
  assign bus.resp_valid_0 = pv_r[2] & ~ptag_r[2];
  assign bus.resp_valid_1 = pv_r[2] & ptag_r[2];
  assign bus.resp_y       = bus.fadd_y;
  assign bus.issue_cnt_0  = cnt_0_r;
  assign bus.issue_cnt_1  = cnt_1_r;
  assign bus.idle         = ~hs_s & ~(|pv_r);

endmodule

// File: tb/tb_fadd_sched.sv
// Bench for fadd_sched: integer-valued float adder stub plus a queue-based
// reference model of grants, responses, counters and idle.
module tb_fadd_sched;
  localparam int CNT_W = 16;
  localparam int CNT_MASK = (1 << CNT_W) - 1;

  typedef struct {
    int          due;
    bit          tag;
    logic [31:0] y;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fadd_sched_if #(.CNT_W(CNT_W)) bus ();
  fadd_sched #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_g = 1;
  int   m_cnt0 = 0;
  int   m_cnt1 = 0;
  rsp_t pq[$];
  int   xi1[2];
  int   xi2[2];
  bit   opi[2];

  // Float encode of small integers (|v| < 2^23).
  function automatic logic [31:0] i2f(input int v);
    int          mag;
    int          p;
    logic [31:0] r;
    r = 32'h0;
    if (v == 0) return r;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  function automatic int f2i(input logic [31:0] b);
    int e;
    int mag;
    if (b[30:0] == 31'h0) return 0;
    e   = int'(b[30:23]) - 127;
    mag = int'({8'h00, 1'b1, b[22:0]}) >> (23 - e);
    return b[31] ? -mag : mag;
  endfunction

  // Shared adder stub: two register stages.
  logic [31:0] add_s1;
  always @(posedge clk) begin
    add_s1     <= i2f(f2i(bus.fadd_x1) + f2i(bus.fadd_x2));
    bus.fadd_y <= add_s1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input bit v, input int x1, input int x2, input bit op);
    xi1[r] = x1;
    xi2[r] = x2;
    opi[r] = op;
    if (r == 0) begin
      bus.req_valid_0 = v;
      bus.req_x1_0    = i2f(x1);
      bus.req_x2_0    = i2f(x2);
      bus.req_op_0    = op;
    end else begin
      bus.req_valid_1 = v;
      bus.req_x1_1    = i2f(x1);
      bus.req_x2_1    = i2f(x2);
      bus.req_op_1    = op;
    end
  endtask

  function automatic int rnd_val();
    return int'($urandom_range(2000)) - 1000;
  endfunction

  // One clock cycle: compare DUT against the model at negedge, then advance.
  task automatic cycle();
    bit   hs;
    int   g;
    bit   have;
    bit   idle_exp;
    int   x2e;
    rsp_t e;
    @(negedge clk);
    hs = 1'b0;
    g  = 0;
    if (!rst_n) begin
      pq.delete();
      last_g = 1;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      hs = bus.req_valid_0 || bus.req_valid_1;
      if (bus.req_valid_0 && bus.req_valid_1) g = 1 - last_g;
      else g = bus.req_valid_1 ? 1 : 0;
    end
    idle_exp = !hs && (pq.size() == 0);
    have = (pq.size() > 0) && (pq[0].due == cyc);
    if (have) e = pq.pop_front();
    check("ready_0", 32'(bus.req_ready_0), 32'(hs && g == 0));
    check("ready_1", 32'(bus.req_ready_1), 32'(hs && g == 1));
    check("resp_valid_0", 32'(bus.resp_valid_0), 32'(have && !e.tag));
    check("resp_valid_1", 32'(bus.resp_valid_1), 32'(have && e.tag));
    if (have) check("resp_y", bus.resp_y, e.y);
    check("idle", 32'(bus.idle), 32'(idle_exp));
    check("issue_cnt_0", 32'(bus.issue_cnt_0), 32'(m_cnt0));
    check("issue_cnt_1", 32'(bus.issue_cnt_1), 32'(m_cnt1));
    if (hs) begin
      x2e = xi2[g];
`ifdef FADD_SCHED_SUB_EN
      if (opi[g]) x2e = -xi2[g];
`endif
      e.due = cyc + 3;
      e.tag = (g == 1);
      e.y   = i2f(xi1[g] + x2e);
      pq.push_back(e);
      last_g = g;
      if (g == 0) m_cnt0 = (m_cnt0 + 1) & CNT_MASK;
      else m_cnt1 = (m_cnt1 + 1) & CNT_MASK;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    set_req(0, 1'b0, 0, 0, 1'b0);
    set_req(1, 1'b0, 0, 0, 1'b0);
    do_reset();

    // Single add from requester 0: 1.0 + 2.0 = 3.0 three cycles later.
    set_req(0, 1'b1, 1, 2, 1'b0);
    cycle();
    set_req(0, 1'b0, 0, 0, 1'b0);
    cycle();
    cycle();
    check("r031_valid", 32'(bus.resp_valid_0), 32'(1));
    check("r031_y", bus.resp_y, 32'h4040_0000);
    for (int i = 0; i < 3; i++) cycle();
    check("r036_idle", 32'(bus.idle), 32'(1));

    // Continuous contention after reset alternates starting with requester 0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b1, 10 + i, i, 1'b0);
      set_req(1, 1'b1, 20 + i, -i, 1'b0);
      cycle();
    end
    check("r032_cnt0", 32'(bus.issue_cnt_0), 32'(3));
    check("r032_cnt1", 32'(bus.issue_cnt_1), 32'(3));
    set_req(0, 1'b0, 0, 0, 1'b0);
    set_req(1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) cycle();

    // Subtract request: 3.0 - 1.0 with the feature, 3.0 + 1.0 without.
    set_req(0, 1'b1, 3, 1, 1'b1);
    cycle();
    set_req(0, 1'b0, 0, 0, 1'b0);
    cycle();
    cycle();
`ifdef FADD_SCHED_SUB_EN
    check("r033_y", bus.resp_y, 32'h4000_0000);
`else
    check("r033_y", bus.resp_y, 32'h4080_0000);
`endif
    for (int i = 0; i < 2; i++) cycle();

    // Reset pulse right after an issue discards it.
    set_req(0, 1'b1, 5, 6, 1'b0);
    cycle();
    set_req(0, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    check("r034_cnt0", 32'(bus.issue_cnt_0), 32'(0));
    check("r034_idle", 32'(bus.idle), 32'(1));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_req(0, 1'($urandom_range(1)), rnd_val(), rnd_val(), 1'($urandom_range(1)));
      set_req(1, 1'($urandom_range(1)), rnd_val(), rnd_val(), 1'($urandom_range(1)));
      cycle();
    end
    set_req(0, 1'b0, 0, 0, 1'b0);
    set_req(1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) cycle();

    // Counter wrap on requester 1.
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      set_req(1, 1'b1, i % 100, 7, 1'($urandom_range(1)));
      cycle();
    end
    check("r035_full", 32'(bus.issue_cnt_1), 32'h0000_FFFF);
    cycle();
    check("r035_wrap", 32'(bus.issue_cnt_1), 32'h0000_0000);
    set_req(1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
